div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider for the MIPS datapath, serving DIV (signed) and DIVU (unsigned) into HI/LO. A synchronous `divrst` pulse samples both operands and starts a restoring shift-subtract division. The division retires one quotient bit per clock. Quotient and remainder are presented as registered outputs when the division completes.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `divrst`  in  1  one clock domain; reset is synchronous and active-high; doubles as the start strobe.
- `a`  in  WIDTH  dividend; sampled only on an edge where `divrst`=1.
- `b`  in  WIDTH  divisor; sampled only on an edge where `divrst`=1.
- `signdiv`  in  1  1 = signed (two's complement), 0 = unsigned; sampled with `a`/`b`.
- `q`  out  WIDTH  quotient (LO).
- `r`  out  WIDTH  remainder (HI).
- `done`  out  1  result valid; present only with `DIV_DONE_EN`.

## Operation
- States: IDLE, BUSY, DONE.
- Edge with `divrst`=1, from any state:
  - latch `signdiv`, sign of `a`, sign of `b`.
  - latch |a| and |b|; magnitudes apply only when signed, raw values otherwise.
  - clear the partial remainder.
  - clear the iteration counter.
  - clear `q`, `r` and `done` to 0.
  - go to BUSY.
- BUSY, each edge:
  - shift {partial remainder, dividend} left by 1.
  - trial-subtract the divisor magnitude, using a WIDTH+1-bit compare.
  - if the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - increment the counter.
- On the 32nd BUSY edge:
  - write the final `q`/`r` with sign correction.
  - set `done`=1 and go to DONE.
- Sign correction, signed mode only:
  - quotient is negated when the operand signs differ.
  - remainder takes the sign of the dividend.
  - the invariant a = q*b + r holds and |r| < |b|.
- DONE: hold `q`, `r` and `done`=1 until the next `divrst`.
- IDLE: entered only out of power-up; outputs are 0 and the block waits for `divrst`.
- Divide by zero (`b`=0), both modes:
  - no trap; the iterations run unchanged.
  - unsigned result: `q`=0xFFFFFFFF, `r`=`a`.
  - signed result is the sign-corrected magnitude result: positive `a` gives `q`=0xFFFFFFFF, `r`=`a`; negative `a` gives `q`=0x00000001, `r`=`a`.
- Signed overflow (0x80000000 / 0xFFFFFFFF): `q`=0x80000000, `r`=0.
- Changes on `a`, `b` or `signdiv` after the start edge have no effect.

## Timing
- Start edge E0 (`divrst`=1) → BUSY on edges E1..E32.
- `q`, `r` and `done` become valid after E32: fixed latency of 32 clocks after the start edge, independent of operand values.
- `divrst` held high for several edges: each edge restarts the operation; counting begins at the first edge with `divrst`=0.
- `divrst` during BUSY aborts the current division at once and restarts it with the new operands. `done` and the outputs are 0 from that edge on.
- Output values during BUSY are 0. Consumers qualify them with `done` or the fixed 32-cycle count.
- After E32, `q`/`r`/`done` are held and no further updates occur.

## Configuration
- `DIV_DONE_EN` defined: the `done` port exists and behaves as above.
- `DIV_DONE_EN` undefined:
  - the `done` port is omitted.
  - the internal state machine, latency and `q`/`r` behaviour are identical.
  - the controller counts 32 cycles externally.

## Structure
- Package `div_pkg` holds:
  - `WIDTH`=32 default.
  - counter width `$clog2(WIDTH)+1`.
  - the state enum `div_state_t` {IDLE, BUSY, DONE}.
- One sub-module, `div_core`: an unsigned iterative restoring engine with counter and FSM.
- Top `div_unit` wraps `div_core` with operand abs-value and final sign correction.

## Test plan
- Unsigned: `a`=0xF0000000, `b`=0x10000000, `signdiv`=0 → 32 edges after `divrst`: `q`=0x0000000F, `r`=0, `done`=1; `done`=0 at 31 edges.
- Signed same operands → `q`=0xFFFFFFFF, `r`=0.
- Signed -7/2 (`a`=0xFFFFFFF9, `b`=2) → `q`=0xFFFFFFFD, `r`=0xFFFFFFFF; unsigned 7/0xFFFFFFFE → `q`=0, `r`=7.
- Divide by zero: unsigned 0x1234/0 → `q`=0xFFFFFFFF, `r`=0x1234; signed overflow 0x80000000/0xFFFFFFFF → `q`=0x80000000, `r`=0.
- Restart mid-operation: start 100/7, assert `divrst` with 100/9 after 10 BUSY edges → `done` stays 0 until 32 edges after the second start, then `q`=11, `r`=1.
- Power-up: `divrst` pulse with no operands changed → `q`=0, `r`=0, `done`=0 on the edge after `divrst`. Outputs are stable across 5 idle edges after DONE.

Source files
------------

// File: rtl/div_pkg.sv
// Shared parameters and state type for the iterative divider.
package div_pkg;

  parameter int unsigned WIDTH = 32;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

endpackage

// File: rtl/div_core.sv
// Unsigned restoring shift-subtract engine: one quotient bit per clock, divrst loads and restarts.
module div_core
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             divrst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             finish
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;

  // dvd_q collects quotient bits from the bottom as dividend bits leave the top.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dsr_q};
    qbit     = ~diff[WIDTH];
    rem_step = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_step = {dvd_q[WIDTH-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    finish  = 1'b0;
    case (state_q)
      BUSY: begin
        rem_d = rem_step;
        dvd_d = dvd_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (divrst) begin
      state_q <= BUSY;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= dividend;
      dsr_q   <= divisor;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
    end
  end

  assign quo = dvd_step;
  assign rem = rem_step;

endmodule

// File: rtl/div_unit.sv
// Signed/unsigned 32-cycle divider wrapper: operand magnitudes in, sign-corrected q/r out.
// Optional `done` port is built when DIV_DONE_EN is defined.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             divrst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signdiv,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
`ifdef DIV_DONE_EN
  ,
  output logic             done
`endif
);

  logic             neg_a, neg_b;
  logic             neg_a_q, neg_b_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] quo, rem;
  logic             finish;
  logic [WIDTH-1:0] q_q, r_q;

  // Sign flags are only ever set in signed mode, so unsigned results pass straight through.
  assign neg_a = signdiv & a[WIDTH-1];
  assign neg_b = signdiv & b[WIDTH-1];
  assign mag_a = neg_a ? (~a + 1'b1) : a;
  assign mag_b = neg_b ? (~b + 1'b1) : b;

  div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .divrst  (divrst),
    .dividend(mag_a),
    .divisor (mag_b),
    .quo     (quo),
    .rem     (rem),
    .finish  (finish)
  );

  always_ff @(posedge clk) begin
    if (divrst) begin
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
      q_q     <= '0;
      r_q     <= '0;
    end else if (finish) begin
      q_q <= (neg_a_q ^ neg_b_q) ? (~quo + 1'b1) : quo;
      r_q <= neg_a_q ? (~rem + 1'b1) : rem;
    end
  end

  assign q = q_q;
  assign r = r_q;

`ifdef DIV_DONE_EN
  logic done_q;

  always_ff @(posedge clk) begin
    if (divrst) begin
      done_q <= 1'b0;
    end else if (finish) begin
      done_q <= 1'b1;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected q/r queued at start, compared 32 edges later.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        divrst = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        signdiv = 1'b0;
  logic [31:0] q, r;
`ifdef DIV_DONE_EN
  logic        done;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t sb_q[$];

  div_unit dut (
    .clk    (clk),
    .divrst (divrst),
    .a      (a),
    .b      (b),
    .signdiv(signdiv),
    .q      (q),
    .r      (r)
`ifdef DIV_DONE_EN
    ,
    .done   (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    int   sx, sy;
    sx = x;
    sy = y;
    if (y == 32'h0) begin
      e.q = (s && x[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      e.r = x;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'h0;
    end else if (s) begin
      e.q = sx / sy;
      e.r = sx % sy;
    end else begin
      e.q = x / y;
      e.r = x % y;
    end
    return e;
  endfunction

  // Drive a start edge, then scramble the operands to show they are not resampled.
  task automatic start_edge(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    divrst  = 1'b1;
    a       = x;
    b       = y;
    signdiv = s;
    @(posedge clk);
    #1;
    divrst  = 1'b0;
    a       = $urandom;
    b       = $urandom;
    signdiv = 1'($urandom);
    check_eq("q_after_start", q, 32'h0);
    check_eq("r_after_start", r, 32'h0);
`ifdef DIV_DONE_EN
    check_eq("done_after_start", {31'h0, done}, 32'h0);
`endif
  endtask

  task automatic finish_check(input string tag, input int hold);
    exp_t e;
    repeat (31) @(posedge clk);
    #1;
    check_eq({tag, "_q_e31"}, q, 32'h0);
    check_eq({tag, "_r_e31"}, r, 32'h0);
`ifdef DIV_DONE_EN
    check_eq({tag, "_done_e31"}, {31'h0, done}, 32'h0);
`endif
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'h0, 32'h1);
      return;
    end
    e = sb_q.pop_front();
    check_eq({tag, "_q"}, q, e.q);
    check_eq({tag, "_r"}, r, e.r);
`ifdef DIV_DONE_EN
    check_eq({tag, "_done"}, {31'h0, done}, 32'h1);
`endif
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check_eq({tag, "_q_hold"}, q, e.q);
      check_eq({tag, "_r_hold"}, r, e.r);
`ifdef DIV_DONE_EN
      check_eq({tag, "_done_hold"}, {31'h0, done}, 32'h1);
`endif
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic s, input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    e.q = eq;
    e.r = er;
    sb_q.push_back(e);
    start_edge(x, y, s);
    finish_check(tag, 0);
  endtask

  initial begin
    exp_t e;
    logic [31:0] x, y;
    logic        s;

    // Power-up: a start pulse with untouched inputs, outputs cleared on that edge.
    sb_q.push_back(model(32'h0, 32'h0, 1'b0));
    start_edge(32'h0, 32'h0, 1'b0);
    finish_check("powerup", 0);

    e.q = 32'h0000_000F;
    e.r = 32'h0;
    sb_q.push_back(e);
    start_edge(32'hF000_0000, 32'h1000_0000, 1'b0);
    finish_check("u_f0_10", 5);

    run_div("s_f0_10",  32'hF000_0000, 32'h1000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0);
    run_div("s_m7_2",   32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("u_7_big",  32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'h0,         32'h7);
    run_div("u_div0",   32'h0000_1234, 32'h0,         1'b0, 32'hFFFF_FFFF, 32'h1234);
    run_div("s_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0);
    run_div("s_div0_p", 32'h0000_0055, 32'h0,         1'b1, 32'hFFFF_FFFF, 32'h55);
    run_div("s_div0_n", 32'hFFFF_FF00, 32'h0,         1'b1, 32'h0000_0001, 32'hFFFF_FF00);

    // Restart after 10 BUSY edges; only the second operation's result is queued.
    start_edge(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    e.q = 32'd11;
    e.r = 32'd1;
    sb_q.push_back(e);
    start_edge(32'd100, 32'd9, 1'b0);
    finish_check("restart", 0);

    // Held start: every edge with divrst high restarts.
    @(negedge clk);
    divrst = 1'b1;
    a = 32'd1000;
    b = 32'd3;
    signdiv = 1'b0;
    repeat (3) @(posedge clk);
    sb_q.push_back(model(32'd1000, 32'd3, 1'b0));
    start_edge(32'd1000, 32'd3, 1'b0);
    finish_check("held", 0);

    for (int i = 0; i < 10; i++) begin
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      s = 1'(i % 2);
      if (i == 4) y = {16'h0, y[15:0]};
      sb_q.push_back(model(x, y, s));
      start_edge(x, y, s);
      finish_check($sformatf("rand%0d", i), (i == 9) ? 5 : 0);
    end

    check_eq("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
